// File: rtl/instruction_fetch_unit.sv
// Fetch stage: program counter, instruction-store addressing and the
// valid/ready hand-off of each fetched word to decode.
module instruction_fetch_unit #(
    parameter logic [9:0]  RESET_PC  = 10'd0,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Start,
    output logic [9:0]  FetchAddress,
    input  logic [15:0] FetchData,
    output logic [15:0] InstrOut,
    output logic [9:0]  PCOut,
    output logic        InstrValid,
    input  logic        DecodeReady,
    input  logic        Redirect,
    input  logic [9:0]  RedirectPC,
    output logic        Halted,
    output logic [15:0] FetchCount
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t         state;
    logic [AW-1:0]  pc;

    // The store is addressed straight from the PC register.
    assign FetchAddress = pc;

    // Fetch control: redirect first, otherwise per-state capture/handshake.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            InstrOut   <= DW'(0);
            PCOut      <= AW'(0);
            InstrValid <= 1'b0;
            Halted     <= 1'b0;
            FetchCount <= CW'(0);
        end else if (Redirect) begin
            // Squash whatever is pending, even if decode is taking it now.
            pc         <= RedirectPC;
            InstrValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) state <= FETCH;
                end
                HALTED: begin
                    state  <= FETCH;
                    Halted <= 1'b0;
                end
                default: ;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (InstrValid && DecodeReady) InstrValid <= 1'b0;
                    if (Start) state <= FETCH;
                end
                FETCH: begin
                    // Capture when the output slot is empty or being drained.
                    if (!InstrValid || DecodeReady) begin
                        InstrOut   <= FetchData;
                        PCOut      <= pc;
                        InstrValid <= 1'b1;
                        pc         <= pc + AW'(1);
                        FetchCount <= FetchCount + CW'(1);
                        if (FetchData == HALT_WORD) begin
                            state  <= HALTED;
                            Halted <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (InstrValid && DecodeReady) InstrValid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Program counter and fetch stage directly upstream of the 1024 x 16-bit instruction store.
- Drives the 10-bit read address, captures the 16-bit word returned combinationally, and presents it to decode with a valid/ready handshake.
- Supports back-pressure stalls, branch/jump redirect with squash, a halt opcode, and 1023->0 address wrap.

Parameters:
- RESET_PC, 10'd0, PC value loaded on reset.
- HALT_WORD, 16'hFFFF, instruction encoding that stops fetching.

Ports:
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- Start  input  1  one-cycle pulse; leaves IDLE and begins fetching.
- FetchAddress  output  10  read address to the instruction store; always equals PC.
- FetchData  input  16  word read combinationally at FetchAddress in the same cycle.
- InstrOut  output  16  instruction held for decode.
- PCOut  output  10  address InstrOut was fetched from.
- InstrValid  output  1  InstrOut/PCOut hold a live instruction.
- DecodeReady  input  1  decode accepts InstrOut this cycle when InstrValid=1.
- Redirect  input  1  branch/jump taken; load RedirectPC and squash.
- RedirectPC  input  10  new fetch address.
- Halted  output  1  high while in HALTED.
- FetchCount  output  16  number of instructions captured, wraps at 16'hFFFF->0.

Behaviour:
- Reset (async, Reset_n=0) sets:
  - State=IDLE, PC=RESET_PC.
  - InstrOut=0, PCOut=0, InstrValid=0.
  - Halted=0, FetchCount=0.
- Every register except State/PC reset only by Reset_n. Release is sampled on the next rising edge.
- States: IDLE, FETCH, HALTED.
- Capture condition in FETCH: Redirect=0 and (InstrValid=0 or DecodeReady=1). On capture at edge N:
  - InstrOut<=FetchData, PCOut<=PC, InstrValid<=1.
  - PC<=PC+1, modulo 1024 (1023 wraps to 0).
  - FetchCount<=FetchCount+1.
- Latency: address presented in cycle N; word visible on InstrOut from cycle N+1. Throughput is 1 instruction/cycle while DecodeReady=1.
- Stall: in FETCH with InstrValid=1 and DecodeReady=0, hold PC, InstrOut, PCOut, InstrValid and FetchCount unchanged.
- Handshake: if InstrValid=1, DecodeReady=1 and no capture occurs (HALTED or IDLE), InstrValid<=0 at that edge.
- Redirect has highest priority, in any state:
  - PC<=RedirectPC.
  - InstrValid<=0 (pending instruction squashed, even if DecodeReady=1).
  - No capture that cycle and FetchCount unchanged.
  - Next state: IDLE stays IDLE unless Start=1 in the same cycle, then FETCH. FETCH stays FETCH. HALTED goes to FETCH with Halted<=0.
- IDLE: no capture. Start=1 -> FETCH next edge. The first capture occurs on the following edge, from PC.
- Halt: a capture whose FetchData==HALT_WORD is still delivered (InstrValid=1), then:
  - State<=HALTED, Halted<=1.
  - PC advances as normal and no further captures occur.
  - The halt word drains to decode normally.
  - Exit only via Redirect or reset.
- Start is ignored outside IDLE.
- Wrap: a capture at PC=1023 yields PCOut=1023 and next PC=0. There is no error flag.

Test Plan:
- Reset, memory[i]=16'h1000+i, Start pulse, DecodeReady=1 -> InstrOut 16'h1000,16'h1001,16'h1002 on consecutive cycles; PCOut 0,1,2; FetchCount 3 after three captures.
- Streaming, DecodeReady low 3 cycles while InstrOut=16'h1004 -> InstrOut, PCOut=4 and FetchAddress=5 held 3 cycles; next cycle InstrOut=16'h1005, no duplicate or skip.
- Redirect=1, RedirectPC=10'd200 while InstrValid=1 and DecodeReady=0 -> InstrValid=0 next cycle, FetchCount unchanged; following cycle InstrOut=memory[200], PCOut=200.
- memory[7]=16'hFFFF -> PCOut=7 delivered with InstrValid=1, Halted=1 next cycle, no capture of address 8, InstrValid drops after accept. Then Redirect to 0 -> Halted=0, fetch resumes from address 0.
- Redirect to 1022, run 3 captures -> PCOut 1022,1023,0.
- Reset_n asserted mid-stall with InstrValid=1 -> all outputs zero immediately (asynchronous), State=IDLE. No capture until a new Start pulse.
